image_sink_rx: RTL

- Receiving end of the simulation video-source interface: consumes active-low vsync, active-high dvalid and pixel data.
- Produces frame-buffer write strobes with linear addresses and per-frame coordinates.
- Measures the received frame geometry and flags timing deviations.
- Sits between the image source (or camera front end) and the frame buffer / recognition pipeline.

---
 rtl/image_sink_rx.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/image_sink_rx.sv
// rtl/image_sink_rx.sv - video-sync receiver producing frame-buffer writes and geometry checks
//
// Purpose: consumes active-low vsync_n, active-high dvalid and din from a video
// source, emits frame-buffer write strobes with linear addresses y*IW+x,
// measures received line/frame geometry and raises sticky timing-error flags.
//
// Ports:
//   clk, reset_1      clock; asynchronous active-high reset
//   vsync_n           frame sync, low during vertical sync
//   dvalid, din       pixel valid and pixel data
//   err_clr           synchronous pulse clearing the sticky error flags
//   wr_en/addr/data   frame-buffer write port (2 clk after din at the port)
//   x_pos, y_pos      coordinates of the pixel on wr_data
//   frame_start/done  1-cycle pulses at start / end of the active frame
//   frame_cnt         completed frames (wrapping)
//   meas_width/height last completed line length / frame line count
//   len_err, cnt_err, ovf_err  sticky line-length, line-count, overflow errors
module image_sink_rx #(
    parameter int IW = 640,
    parameter int IH = 512,
    parameter int DW = 8,
    parameter int AW = 19
) (
    input  logic          clk,
    input  logic          reset_1,
    input  logic          vsync_n,
    input  logic          dvalid,
    input  logic [DW-1:0] din,
    input  logic          err_clr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [10:0]   x_pos,
    output logic [10:0]   y_pos,
    output logic          frame_start,
    output logic          frame_done,
    output logic [15:0]   frame_cnt,
    output logic [10:0]   meas_width,
    output logic [10:0]   meas_height,
    output logic          len_err,
    output logic          cnt_err,
    output logic          ovf_err
);

    localparam logic [10:0]   IW_C = 11'(IW);
    localparam logic [10:0]   IH_C = 11'(IH);
    localparam logic [10:0]   CMAX = 11'h7FF;
    localparam logic [AW-1:0] IW_A = AW'(IW);

    typedef enum logic [1:0] {WAIT_SYNC, SYNC, ACTIVE} state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CMAX) ? v : v + 11'd1;
    endfunction

    state_t          state_q, state_d;
    logic            vs_q, vs_prev_q, dv_q, dv_prev_q;
    logic [DW-1:0]   din_q;
    logic [10:0]     x_q, x_d, y_q, y_d;
    logic [AW-1:0]   row_base_q, row_base_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [10:0]     x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic            frame_start_q, frame_start_d, frame_done_q, frame_done_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [10:0]     meas_width_q, meas_width_d, meas_height_q, meas_height_d;
    logic            len_err_q, cnt_err_q, ovf_err_q;
    logic            len_set, cnt_set, ovf_set;
    logic            vs_fall, vs_rise, dv_fall, line_close;
    logic [10:0]     y_close;
    logic [AW-1:0]   pix_addr;

    assign vs_fall  = vs_prev_q & ~vs_q;
    assign vs_rise  = ~vs_prev_q & vs_q;
    assign dv_fall  = dv_prev_q & ~dv_q;
    assign pix_addr = row_base_q + AW'(x_q);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        row_base_d    = row_base_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        x_pos_d       = x_pos_q;
        y_pos_d       = y_pos_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        meas_width_d  = meas_width_q;
        meas_height_d = meas_height_q;
        len_set       = 1'b0;
        cnt_set       = 1'b0;
        ovf_set       = 1'b0;
        line_close    = 1'b0;
        y_close       = y_q;

        case (state_q)
            WAIT_SYNC: begin
                // Only a fresh vsync fall arms capture, so no partial frame is taken.
                if (vs_fall) state_d = SYNC;
            end
            SYNC: begin
                if (vs_rise) begin
                    state_d       = ACTIVE;
                    frame_start_d = 1'b1;
                    x_d           = '0;
                    y_d           = '0;
                    row_base_d    = '0;
                end
            end
            ACTIVE: begin
                // A line that is still open when vsync falls is closed in the same
                // cycle so the frame check sees its row. x_q==0 means no line open.
                line_close = (x_q != 11'd0) & (dv_fall | (vs_fall & dv_q));

                if (dv_q && !vs_fall) begin
                    wr_data_d = din_q;
                    x_pos_d   = x_q;
                    y_pos_d   = y_q;
                    if (x_q < IW_C && y_q < IH_C) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pix_addr;
                    end else begin
                        ovf_set = 1'b1;
                    end
                    x_d = sat_inc(x_q);
                end

                if (line_close) begin
                    meas_width_d = x_q;
                    len_set      = (x_q != IW_C);
                    y_close      = sat_inc(y_q);
                    y_d          = y_close;
                    // Row base stops advancing past the last row so it cannot wrap.
                    if (y_q < IH_C) row_base_d = row_base_q + IW_A;
                    x_d = '0;
                end

                if (vs_fall) begin
                    meas_height_d = y_close;
                    cnt_set       = (y_close != IH_C);
                    frame_done_d  = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                    state_d       = SYNC;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset_1) begin
        if (reset_1) begin
            state_q       <= WAIT_SYNC;
            vs_q          <= 1'b1;
            vs_prev_q     <= 1'b1;
            dv_q          <= 1'b0;
            dv_prev_q     <= 1'b0;
            din_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            row_base_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            x_pos_q       <= '0;
            y_pos_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            meas_width_q  <= '0;
            meas_height_q <= '0;
            len_err_q     <= 1'b0;
            cnt_err_q     <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vsync_n;
            vs_prev_q     <= vs_q;
            dv_q          <= dvalid;
            dv_prev_q     <= dv_q;
            din_q         <= din;
            x_q           <= x_d;
            y_q           <= y_d;
            row_base_q    <= row_base_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            x_pos_q       <= x_pos_d;
            y_pos_q       <= y_pos_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            meas_width_q  <= meas_width_d;
            meas_height_q <= meas_height_d;
            // A set in the same cycle as err_clr takes priority.
            len_err_q     <= (len_err_q & ~err_clr) | len_set;
            cnt_err_q     <= (cnt_err_q & ~err_clr) | cnt_set;
            ovf_err_q     <= (ovf_err_q & ~err_clr) | ovf_set;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign x_pos       = x_pos_q;
    assign y_pos       = y_pos_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign meas_width  = meas_width_q;
    assign meas_height = meas_height_q;
    assign len_err     = len_err_q;
    assign cnt_err     = cnt_err_q;
    assign ovf_err     = ovf_err_q;

endmodule
